midi_msg_receiver: RTL

// Parametrised MIDI input front end. Oversampling UART receiver: 8N1, LSB first, idle high.

---
 rtl/midi_msg_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/midi_msg_receiver.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | midi_msg_receiver: oversampling 8N1 MIDI UART + note-on/off parser, LEDs  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module midi_msg_receiver #(
   parameter int         CLKS_PER_BIT = 128,
   parameter bit         CHAN_FILT_EN = 1'b0,
   parameter logic [3:0] CHANNEL      = 4'd0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       DATA,
   output logic [6:0] NOTE,
   output logic [6:0] VELOCITY,
   output logic [3:0] CHAN,
   output logic       NOTE_ON,
   output logic       MSG_VALID,
   output logic       FRAME_ERR,
   output logic [7:0] LED
);

   localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_SHIFT     = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } bit_state_t;

   typedef enum logic [1:0] {
      P_WAIT_STATUS = 2'd0,
      P_GOT_STATUS  = 2'd1,
      P_GOT_NOTE    = 2'd2
   } parse_state_t;

   logic [1:0]         r_sync;
   logic               r_rx;
   bit_state_t         r_bstate;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bitcnt;
   logic [7:0]         r_shift;
   logic               r_byte_rdy;

   parse_state_t       r_pstate;
   logic               r_is_on;
   logic [3:0]         r_chan;
   logic [6:0]         r_note;

   logic [6:0]         w_vel;
   logic               w_note_on;
   logic               w_chan_ok;

   assign r_rx      = r_sync[1];
   assign w_vel     = r_shift[6:0];
   assign w_note_on = r_is_on && (w_vel != 7'd0);
   assign w_chan_ok = !CHAN_FILT_EN || (r_chan == CHANNEL);

   // Synchroniser resets to idle-high so no false start bit follows reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], DATA};
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_bstate   <= S_IDLE;
         r_cnt      <= '0;
         r_bitcnt   <= 3'd0;
         r_shift    <= 8'h00;
         r_byte_rdy <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         r_byte_rdy <= 1'b0;
         FRAME_ERR  <= 1'b0;
         case (r_bstate)
            S_IDLE: begin
               r_cnt <= '0;
               if (!r_rx) r_bstate <= S_START;
            end
            S_START: begin
               if (r_cnt == c_HALF) begin
                  r_cnt    <= '0;
                  r_bitcnt <= 3'd0;
                  r_bstate <= r_rx ? S_IDLE : S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               if (r_cnt == c_LAST) begin
                  r_cnt    <= '0;
                  r_shift  <= {r_rx, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_bstate <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == c_LAST) begin
                  r_cnt <= '0;
                  if (r_rx) begin
                     r_byte_rdy <= 1'b1;
                     r_bstate   <= S_IDLE;
                  end else begin
                     FRAME_ERR <= 1'b1;
                     r_bstate  <= S_WAIT_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               if (r_rx) r_bstate <= S_IDLE;
            end
            default: r_bstate <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_pstate  <= P_WAIT_STATUS;
         r_is_on   <= 1'b0;
         r_chan    <= 4'd0;
         r_note    <= 7'd0;
         NOTE      <= 7'd0;
         VELOCITY  <= 7'd0;
         CHAN      <= 4'd0;
         NOTE_ON   <= 1'b0;
         MSG_VALID <= 1'b0;
         LED       <= 8'h00;
      end else begin
         MSG_VALID <= 1'b0;
         if (FRAME_ERR) begin
            r_pstate <= P_WAIT_STATUS;
         end else if (r_byte_rdy && (r_shift < 8'hF8)) begin
            if (r_shift[7]) begin
               if (r_shift[7:5] == 3'b100) begin
                  r_is_on  <= r_shift[4];
                  r_chan   <= r_shift[3:0];
                  r_pstate <= P_GOT_STATUS;
               end else begin
                  r_is_on  <= 1'b0;
                  r_chan   <= 4'd0;
                  r_pstate <= P_WAIT_STATUS;
               end
            end else begin
               case (r_pstate)
                  P_GOT_STATUS: begin
                     r_note   <= w_vel;
                     r_pstate <= P_GOT_NOTE;
                  end
                  P_GOT_NOTE: begin
                     r_pstate <= P_GOT_STATUS;
                     if (w_chan_ok) begin
                        MSG_VALID <= 1'b1;
                        NOTE      <= r_note;
                        VELOCITY  <= w_vel;
                        CHAN      <= r_chan;
                        NOTE_ON   <= w_note_on;
                        // Note-off only releases the LED if it is the note on display.
                        if (w_note_on)
                           LED <= {1'b1, r_note};
                        else if (LED == {1'b1, r_note})
                           LED <= 8'h00;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire
